// File: rtl/div_mon_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding
// and default timing constants.
package div_mon_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_EXP_HIGH = 5;
    localparam int DEF_EXP_LOW  = 5;
    localparam int DEF_LOCK_CNT = 4;

endpackage

// File: rtl/div_clk_monitor_edge_detect.sv
// Edge detector for the monitored square wave. sig is sampled once into
// sig_q and delayed again into sig_d; rise/fall are decoded from the pair.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic sig_q,
    output logic rise,
    output logic fall
);

    logic sig_d;

    // Two-stage sample of sig, cleared by reset so a high sig after reset reads as a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sig_q <= sig;
            sig_d <= sig_q;
        end
    end

    assign rise = sig_q & ~sig_d;
    assign fall = ~sig_q & sig_d;

endmodule

// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: measures high/low times of sig, reports each
// complete period, flags mismatches against EXP_HIGH/EXP_LOW and raises
// locked after LOCK_CNT consecutive good periods.
// Optional feature macro: DIV_MON_TIMEOUT_EN adds a timeout output that
// fires when a length counter saturates and forces resynchronisation.
// Handshake: period_valid is a single-cycle strobe with no back-pressure;
// high_len/low_len/err are meaningful in the cycle period_valid is high.
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EXP_HIGH = DEF_EXP_HIGH,
    parameter int EXP_LOW  = DEF_EXP_LOW,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             period_valid,
    output logic             err,
    output state_e           dbg_state,
    output logic             locked
`ifdef DIV_MON_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam int               RUN_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

    logic sig_q, rise, fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] high_len_q, high_len_d;
    logic [CNT_W-1:0] low_len_q, low_len_d;
    logic             pv_q, pv_d;
    logic             err_q, err_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             good;
`ifdef DIV_MON_TIMEOUT_EN
    logic             timeout_q, timeout_d;
`endif

    edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .sig   (sig),
        .sig_q (sig_q),
        .rise  (rise),
        .fall  (fall)
    );

    // A period is good only on an exact match; a saturated count never is.
    assign good = (hold_q == CNT_W'(EXP_HIGH)) && (lcnt_q == CNT_W'(EXP_LOW)) &&
                  (hold_q != CNT_MAX) && (lcnt_q != CNT_MAX);

    // Next-state, counters and report generation.
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        lcnt_d     = lcnt_q;
        hold_d     = hold_q;
        high_len_d = high_len_q;
        low_len_d  = low_len_q;
        pv_d       = 1'b0;
        err_d      = 1'b0;
        run_d      = run_q;
`ifdef DIV_MON_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            SYNC: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = CNT_ONE;
`ifdef DIV_MON_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            HIGH: begin
                if (fall) begin
                    hold_d  = hcnt_q;
                    lcnt_d  = CNT_ONE;
                    state_d = LOW;
                end else if (sig_q && (hcnt_q != CNT_MAX)) begin
                    hcnt_d = hcnt_q + CNT_ONE;
                end
            end
            LOW: begin
                if (rise) begin
                    high_len_d = hold_q;
                    low_len_d  = lcnt_q;
                    pv_d       = 1'b1;
                    err_d      = ~good;
                    if (!good)
                        run_d = '0;
                    else if (run_q != RUN_MAX)
                        run_d = run_q + RUN_W'(1);
                    hcnt_d  = CNT_ONE;
                    state_d = HIGH;
                end else if (!sig_q && (lcnt_q != CNT_MAX)) begin
                    lcnt_d = lcnt_q + CNT_ONE;
                end
            end
            default: state_d = SYNC;
        endcase
`ifdef DIV_MON_TIMEOUT_EN
        // A stuck wave drops the monitor back to SYNC and loses lock.
        if (((state_d == HIGH) && (hcnt_d == CNT_MAX)) ||
            ((state_d == LOW) && (lcnt_d == CNT_MAX))) begin
            timeout_d = 1'b1;
            state_d   = SYNC;
            run_d     = '0;
        end
`endif
    end

    // State and datapath registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SYNC;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            hold_q     <= '0;
            high_len_q <= '0;
            low_len_q  <= '0;
            pv_q       <= 1'b0;
            err_q      <= 1'b0;
            run_q      <= '0;
`ifdef DIV_MON_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            lcnt_q     <= lcnt_d;
            hold_q     <= hold_d;
            high_len_q <= high_len_d;
            low_len_q  <= low_len_d;
            pv_q       <= pv_d;
            err_q      <= err_d;
            run_q      <= run_d;
`ifdef DIV_MON_TIMEOUT_EN
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign high_len     = high_len_q;
    assign low_len      = low_len_q;
    assign period_valid = pv_q;
    assign err          = err_q;
    assign locked       = (run_q == RUN_MAX);
    assign dbg_state    = state_q;
`ifdef DIV_MON_TIMEOUT_EN
    assign timeout      = timeout_q;
`endif

endmodule
